// File: rtl/bp_me_wormhole_lce_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// bp_me_wormhole_lce_cmd_arbiter
//
// Purpose:
//   Shares one LCE command injection port among num_req_p wormhole flit
//   sources. Header flits are arbitrated round-robin. A winner keeps the
//   grant until the last flit of its packet has been accepted, so packets
//   are never interleaved on the wormhole link. Flits pass through
//   combinationally with zero cycles of latency.
//
// Ports:
//   clk_i       - clock
//   reset_n_i   - asynchronous active-low reset; also forces all outputs low
//   flit_i      - per-requester flits, requester r at [r*flit_width_p +: flit_width_p]
//   v_i         - per-requester valid
//   ready_o     - per-requester ready
//   flit_o      - flit forwarded to the network
//   v_o         - output valid (never depends on ready_i)
//   ready_i     - network ready
//   grant_id_o  - index of the requester currently forwarded
//   busy_o      - high while a packet is in flight (state != IDLE)
// ---------------------------------------------------------------------------
module bp_me_wormhole_lce_cmd_arbiter #(
  parameter int num_req_p    = 4,
  parameter int flit_width_p = 64,
  parameter int cord_width_p = 8,
  parameter int cid_width_p  = 2,
  parameter int len_width_p  = 4,
  parameter int lg_num_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [num_req_p*flit_width_p-1:0] flit_i,
  input  logic [num_req_p-1:0]              v_i,
  output logic [num_req_p-1:0]              ready_o,
  output logic [flit_width_p-1:0]           flit_o,
  output logic                              v_o,
  input  logic                              ready_i,
  output logic [lg_num_req_lp-1:0]          grant_id_o,
  output logic                              busy_o
);

  localparam int len_lsb_lp = cord_width_p + cid_width_p;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [lg_num_req_lp-1:0] grant_q, grant_d;
  logic [lg_num_req_lp-1:0] rr_ptr_q, rr_ptr_d;
  logic [len_width_p-1:0]   cnt_q, cnt_d;

  // Per-requester view of the packed flit bus.
  logic [flit_width_p-1:0] flit_arr [num_req_p];

  for (genvar gi = 0; gi < num_req_p; gi++) begin : g_unpack
    assign flit_arr[gi] = flit_i[gi*flit_width_p +: flit_width_p];
  end

  // Round-robin candidate: first valid requester after rr_ptr_q, wrapping.
  logic                     any_v;
  logic [lg_num_req_lp-1:0] cand;

  always_comb begin
    int                       k;
    logic [lg_num_req_lp-1:0] idx;
    any_v = 1'b0;
    cand  = '0;
    for (int i = 0; i < num_req_p; i++) begin
      k   = (int'(rr_ptr_q) + 1 + i) % num_req_p;
      idx = lg_num_req_lp'(k);
      if (!any_v && v_i[idx]) begin
        any_v = 1'b1;
        cand  = idx;
      end
    end
  end

  // Routing: in IDLE the live candidate is forwarded; once a header has been
  // offered (HDR) or accepted (BODY) the selection is frozen in grant_q.
  logic [lg_num_req_lp-1:0] sel;
  logic                     v_raw;
  logic                     route_active;
  logic [len_width_p-1:0]   len_sel;
  logic                     hs;

  always_comb begin
    if (state_q == IDLE) begin
      sel          = cand;
      v_raw        = any_v;
      route_active = any_v;
    end else begin
      sel          = grant_q;
      v_raw        = v_i[grant_q];
      route_active = 1'b1;
    end
    len_sel = flit_arr[sel][len_lsb_lp +: len_width_p];
    hs      = v_raw & ready_i;
  end

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= lg_num_req_lp'(num_req_p - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (any_v) begin
          if (ready_i) begin
            rr_ptr_d = cand;
            // A header-only packet leaves us in IDLE so the next packet can
            // be arbitrated in the very next cycle.
            if (len_sel != '0) begin
              state_d = BODY;
              cnt_d   = len_sel;
              grant_d = cand;
            end
          end else begin
            // Freeze the offered header so flit_o stays stable under stall.
            state_d = HDR;
            grant_d = cand;
          end
        end
      end
      HDR: begin
        if (hs) begin
          rr_ptr_d = grant_q;
          if (len_sel != '0) begin
            state_d = BODY;
            cnt_d   = len_sel;
          end else begin
            state_d = IDLE;
          end
        end
      end
      BODY: begin
        if (hs) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == len_width_p'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic; everything is held low while reset is asserted.
  always_comb begin
    v_o        = 1'b0;
    flit_o     = '0;
    ready_o    = '0;
    grant_id_o = '0;
    busy_o     = 1'b0;
    if (reset_n_i) begin
      v_o        = v_raw;
      flit_o     = flit_arr[sel];
      busy_o     = (state_q != IDLE);
      grant_id_o = (state_q == IDLE && !any_v) ? rr_ptr_q : sel;
      if (ready_i && route_active) begin
        ready_o[sel] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bp_me_wormhole_lce_cmd_arbiter.sv
module tb_bp_me_wormhole_lce_cmd_arbiter;

  localparam int NR = 4;
  localparam int FW = 64;

  logic            clk_i = 1'b0;
  logic            reset_n_i;
  logic [NR*FW-1:0] flit_i;
  logic [NR-1:0]   v_i;
  logic [NR-1:0]   ready_o;
  logic [FW-1:0]   flit_o;
  logic            v_o;
  logic            ready_i;
  logic [1:0]      grant_id_o;
  logic            busy_o;

  int checks   = 0;
  int failures = 0;

  bp_me_wormhole_lce_cmd_arbiter #(
    .num_req_p(NR), .flit_width_p(FW), .cord_width_p(8),
    .cid_width_p(2), .len_width_p(4)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .flit_i(flit_i), .v_i(v_i),
    .ready_o(ready_o), .flit_o(flit_o), .v_o(v_o), .ready_i(ready_i),
    .grant_id_o(grant_id_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // One cycle of stimulus and the outputs required in that cycle.
  // len/tag hold one nibble per requester (requester r at [4r+:4]).
  typedef struct {
    logic        rst_n;
    logic [3:0]  v;
    logic [15:0] len;
    logic [15:0] tag;
    logic        rdy;
    logic        ev;
    logic [3:0]  erdy;
    logic [1:0]  egid;
    logic        ebusy;
  } vec_t;

  vec_t vecs[$];

  // Header layout {payload, len, cid, cord}; payload carries tag and source id.
  function automatic logic [FW-1:0] mk(input int r, input logic [3:0] len, input logic [3:0] tag);
    logic [FW-1:0] f;
    f        = '0;
    f[7:0]   = 8'(r * 16 + 3);
    f[9:8]   = 2'(r);
    f[13:10] = len;
    f[17:14] = tag;
    f[19:18] = 2'(r);
    return f;
  endfunction

  function automatic vec_t V(input logic rst_n, input logic [3:0] v,
                             input logic [15:0] len, input logic [15:0] tag,
                             input logic rdy, input logic ev, input logic [3:0] erdy,
                             input logic [1:0] egid, input logic ebusy);
    vec_t x;
    x.rst_n = rst_n; x.v = v; x.len = len; x.tag = tag; x.rdy = rdy;
    x.ev = ev; x.erdy = erdy; x.egid = egid; x.ebusy = ebusy;
    return x;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t x);
    reset_n_i = x.rst_n;
    v_i       = x.v;
    ready_i   = x.rdy;
    for (int r = 0; r < NR; r++)
      flit_i[r*FW +: FW] = mk(r, x.len[r*4 +: 4], x.tag[r*4 +: 4]);
  endtask

  initial begin
    reset_n_i = 1'b0;
    v_i       = '0;
    ready_i   = 1'b0;
    flit_i    = '0;

    // 1: reset, then requester 2 sends header len=3 plus 3 body flits
    vecs.push_back(V(0, 4'b0100, 16'h0300, 16'h0100, 1, 0, 4'b0000, 0, 0));
    vecs.push_back(V(0, 4'b0100, 16'h0300, 16'h0100, 1, 0, 4'b0000, 0, 0));
    vecs.push_back(V(1, 4'b0100, 16'h0300, 16'h0100, 1, 1, 4'b0100, 2, 0));
    vecs.push_back(V(1, 4'b0100, 16'h0000, 16'h0200, 1, 1, 4'b0100, 2, 1));
    vecs.push_back(V(1, 4'b0100, 16'h0000, 16'h0300, 1, 1, 4'b0100, 2, 1));
    vecs.push_back(V(1, 4'b0100, 16'h0000, 16'h0400, 1, 1, 4'b0100, 2, 1));
    vecs.push_back(V(1, 4'b0000, 16'h0000, 16'h0000, 1, 0, 4'b0000, 2, 0));
    // 2: all four contend with len=1 packets from reset: order 0,1,2,3,0
    vecs.push_back(V(0, 4'b1111, 16'h1111, 16'h1111, 1, 0, 4'b0000, 0, 0));
    vecs.push_back(V(1, 4'b1111, 16'h1111, 16'h1111, 1, 1, 4'b0001, 0, 0));
    vecs.push_back(V(1, 4'b1111, 16'h1110, 16'h1112, 1, 1, 4'b0001, 0, 1));
    vecs.push_back(V(1, 4'b1111, 16'h1111, 16'h1111, 1, 1, 4'b0010, 1, 0));
    vecs.push_back(V(1, 4'b1111, 16'h1101, 16'h1121, 1, 1, 4'b0010, 1, 1));
    vecs.push_back(V(1, 4'b1111, 16'h1111, 16'h1111, 1, 1, 4'b0100, 2, 0));
    vecs.push_back(V(1, 4'b1111, 16'h1011, 16'h1211, 1, 1, 4'b0100, 2, 1));
    vecs.push_back(V(1, 4'b1111, 16'h1111, 16'h1111, 1, 1, 4'b1000, 3, 0));
    vecs.push_back(V(1, 4'b1111, 16'h0111, 16'h2111, 1, 1, 4'b1000, 3, 1));
    vecs.push_back(V(1, 4'b1111, 16'h1111, 16'h1111, 1, 1, 4'b0001, 0, 0));
    vecs.push_back(V(1, 4'b1111, 16'h1110, 16'h1112, 1, 1, 4'b0001, 0, 1));
    // 3: header backpressure on requester 1; requester 0 arrives during stall
    vecs.push_back(V(1, 4'b0010, 16'h0000, 16'h0050, 0, 1, 4'b0000, 1, 0));
    vecs.push_back(V(1, 4'b0011, 16'h0000, 16'h0056, 0, 1, 4'b0000, 1, 1));
    vecs.push_back(V(1, 4'b0011, 16'h0000, 16'h0056, 0, 1, 4'b0000, 1, 1));
    vecs.push_back(V(1, 4'b0011, 16'h0000, 16'h0056, 1, 1, 4'b0010, 1, 1));
    vecs.push_back(V(1, 4'b0001, 16'h0000, 16'h0006, 1, 1, 4'b0001, 0, 0));
    // 4: len=2 from requester 2 with bubbles and stalls; requester 3 waits
    vecs.push_back(V(1, 4'b1100, 16'h0200, 16'h7100, 1, 1, 4'b0100, 2, 0));
    vecs.push_back(V(1, 4'b1000, 16'h0000, 16'h7100, 1, 0, 4'b0100, 2, 1));
    vecs.push_back(V(1, 4'b1000, 16'h0000, 16'h7100, 1, 0, 4'b0100, 2, 1));
    vecs.push_back(V(1, 4'b1100, 16'h0000, 16'h7200, 0, 1, 4'b0000, 2, 1));
    vecs.push_back(V(1, 4'b1100, 16'h0000, 16'h7200, 1, 1, 4'b0100, 2, 1));
    vecs.push_back(V(1, 4'b1100, 16'h0000, 16'h7300, 0, 1, 4'b0000, 2, 1));
    vecs.push_back(V(1, 4'b1100, 16'h0000, 16'h7300, 1, 1, 4'b0100, 2, 1));
    vecs.push_back(V(1, 4'b1000, 16'h0000, 16'h7000, 1, 1, 4'b1000, 3, 0));
    // 5: zero-length headers back to back from requesters 0 and 3
    vecs.push_back(V(1, 4'b1001, 16'h0000, 16'h2001, 1, 1, 4'b0001, 0, 0));
    vecs.push_back(V(1, 4'b1001, 16'h0000, 16'h2001, 1, 1, 4'b1000, 3, 0));
    vecs.push_back(V(1, 4'b1001, 16'h0000, 16'h2001, 1, 1, 4'b0001, 0, 0));
    vecs.push_back(V(1, 4'b1001, 16'h0000, 16'h2001, 1, 1, 4'b1000, 3, 0));

    foreach (vecs[i]) begin
      @(negedge clk_i);
      apply(vecs[i]);
      #1;
      chk("v_o", i, 64'(v_o), 64'(vecs[i].ev));
      chk("ready_o", i, 64'(ready_o), 64'(vecs[i].erdy));
      chk("grant_id_o", i, 64'(grant_id_o), 64'(vecs[i].egid));
      chk("busy_o", i, 64'(busy_o), 64'(vecs[i].ebusy));
      if (!vecs[i].rst_n)
        chk("flit_o_reset", i, flit_o, 64'(0));
      else if (vecs[i].ev)
        chk("flit_o", i, flit_o,
            mk(int'(vecs[i].egid), vecs[i].len[vecs[i].egid*4 +: 4],
               vecs[i].tag[vecs[i].egid*4 +: 4]));
    end

    // 6: reset in the middle of a len=2 packet, asserted and released
    // between clock edges; the packet must be gone without any clock edge.
    @(negedge clk_i);
    v_i = 4'b0010; ready_i = 1'b1; flit_i = '0;
    flit_i[1*FW +: FW] = mk(1, 4'd2, 4'd9);
    #1;
    chk("r6_hdr_grant", 100, 64'(grant_id_o), 64'(1));
    chk("r6_hdr_v", 100, 64'(v_o), 64'(1));
    @(posedge clk_i);
    #2;
    chk("r6_body_busy", 101, 64'(busy_o), 64'(1));
    reset_n_i = 1'b0;
    #1;
    chk("r6_rst_v_o", 102, 64'(v_o), 64'(0));
    chk("r6_rst_ready_o", 102, 64'(ready_o), 64'(0));
    chk("r6_rst_busy_o", 102, 64'(busy_o), 64'(0));
    #1;
    reset_n_i = 1'b1;
    v_i = 4'b0000;
    #1;
    chk("r6_rel_busy_o", 103, 64'(busy_o), 64'(0));
    chk("r6_rel_grant_id", 103, 64'(grant_id_o), 64'(3));
    chk("r6_rel_v_o", 103, 64'(v_o), 64'(0));
    v_i = 4'b0011;
    flit_i[0*FW +: FW] = mk(0, 4'd0, 4'd1);
    flit_i[1*FW +: FW] = mk(1, 4'd0, 4'd9);
    #1;
    chk("r6_restart_grant", 104, 64'(grant_id_o), 64'(0));
    chk("r6_restart_ready", 104, 64'(ready_o), 64'(4'b0001));
    chk("r6_restart_flit", 104, flit_o, mk(0, 4'd0, 4'd1));
    @(posedge clk_i);
    #1;
    chk("r6_next_grant", 105, 64'(grant_id_o), 64'(1));
    chk("r6_next_busy", 105, 64'(busy_o), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bp_me_wormhole_lce_cmd_arbiter.md
Name: bp_me_wormhole_lce_cmd_arbiter

Overview:
- Shares one coherence-network LCE command injection port among num_req_p wormhole flit sources, for example several CCE command streams in a multi-CCE tile.
- Each packet's header flit carries {payload, len, cid, cord}, with len at bits [cord_width_p+cid_width_p +: len_width_p] and len = number of flits after the header.
- Grants round-robin on header flits and holds the grant until the last flit of that packet has been accepted, so packets are never interleaved on the wormhole link.
- Sits between the packet-encode/flit-serialization stage and the wormhole router/concentrator input.

Parameters:
num_req_p, 4, number of requesters (>=2)
flit_width_p, 64, flit width in bits
cord_width_p, 8, cord field width
cid_width_p, 2, cid field width
len_width_p, 4, len field width
lg_num_req_lp, `BSG_SAFE_CLOG2(num_req_p), local; grant index width

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous, active-low reset
flit_i  in  num_req_p*flit_width_p  per-requester flit; requester r occupies [r*flit_width_p +: flit_width_p]
v_i  in  num_req_p  per-requester valid
ready_o  out  num_req_p  per-requester ready (ready-valid handshake)
flit_o  out  flit_width_p  flit to network
v_o  out  1  output valid
ready_i  in  1  network ready
grant_id_o  out  lg_num_req_lp  index of the requester currently forwarded
busy_o  out  1  1 when state != IDLE

Behaviour:
- Interface rules:
  - Handshake on an input or the output = v & ready in the same cycle.
  - v_o never depends combinationally on ready_i.
  - ready_o[r] = ready_i & (r == grant) & routing_active.
  - Sources hold v_i and the flit stable until accepted.
- State: IDLE, HDR, BODY. Registers: state, grant_r, cnt_r (len_width_p bits), rr_ptr_r (last granted index).
- Reset (reset_n_i low, asynchronous):
  - state=IDLE, cnt_r=0, rr_ptr_r=num_req_p-1, so requester 0 has first priority.
  - Outputs: v_o=0, ready_o=0, busy_o=0, grant_id_o=0, flit_o=0.
  - Asserting reset mid-packet drops the packet state immediately. Upstream sources are reset in the same domain.
- IDLE:
  - Candidate = first r with v_i[r], searching from rr_ptr_r+1 upward with wrap-around.
  - If any v_i: v_o=1, flit_o=flit_i[cand], grant_id_o=cand.
  - Header handshake with len==0: stay IDLE, rr_ptr_r<=cand.
  - Header handshake with len!=0: go BODY, cnt_r<=len, grant_r<=cand, rr_ptr_r<=cand.
  - v_o=1 without ready_i: go HDR with grant_r<=cand. The selection is frozen so flit_o stays stable.
  - No v_i: v_o=0, grant_id_o=rr_ptr_r.
- HDR:
  - Forward grant_r only; v_o=v_i[grant_r].
  - On handshake, apply the same len decision as IDLE: len==0 goes to IDLE, otherwise go BODY with cnt_r<=len.
  - rr_ptr_r<=grant_r.
- BODY:
  - Forward grant_r only; v_o=v_i[grant_r]. Other requesters see ready_o=0 even when ready_i=1.
  - Each handshake decrements cnt_r. A handshake with cnt_r==1 returns to IDLE.
  - A bubble (v_i[grant_r]=0) holds state and count.
- Latency: zero-cycle combinational pass-through. A 1-flit packet can follow back-to-back in the next cycle, with no idle cycle between packets.
- Max len = 2^len_width_p-1. There is no overflow because cnt_r is loaded directly from len.
- Simultaneous requests in IDLE resolve strictly by round-robin from rr_ptr_r+1. A requester granted last waits until all other active requesters have been served once.

Test Plan:
1. Reset and single packet. Assert then release reset_n_i; requester 2 sends a header with len=3 plus 3 body flits, ready_i=1 throughout. Required: v_o=0 during reset; 4 consecutive output flits with grant_id_o=2; busy_o=1 for cycles 1-3; back to IDLE after the 4th flit.
2. Contention and no interleave. All 4 requesters valid with len=1 packets from reset. Required: grant order 0,1,2,3,0; each grant's 2 flits are contiguous; ready_o is one-hot or zero in every cycle.
3. Backpressure on header. Requester 1 valid with ready_i=0 for 3 cycles, and requester 0 raises v_i in the 2nd cycle. Required: state HDR; flit_o and grant_id_o=1 stay stable; requester 1 is sent first once ready_i=1.
4. Body bubbles and stalls. len=2, with v_i[grant] dropped for 2 cycles mid-body and ready_i toggling. Required: cnt_r holds; exactly 3 output handshakes; no flit from another requester in between.
5. Zero-length back-to-back. Requesters 0 and 3 each stream len=0 headers continuously. Required: the output alternates 0,3,0,3 on consecutive cycles and busy_o stays 0.
6. Reset mid-packet. Assert reset_n_i during BODY with cnt_r=2. Required: v_o, ready_o and busy_o go to 0 asynchronously; after release, arbitration restarts at requester 0 from IDLE.
